// File: rtl/ecc_175_enc_fault_detc_if.sv
// Write-path bus for the 175-bit SECDED encoder.
// The upstream side drives in_valid/data_in and the downstream side drives out_ready.
// The encoder takes the slave modport.
interface ecc_175_enc_fault_detc_if #(
    parameter int DATA_WIDTH   = 175,
    parameter int PARITY_WIDTH = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [PARITY_WIDTH-1:0] parity_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, parity_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, parity_out
    );
endinterface

// File: rtl/ecc_175_enc_fault_detc.sv
// FIFO write-path SECDED encoder with a lockstep (duplicated) parity generator.
//
// Parity layout: data bits occupy Hamming code positions 1..2^(PW-1)-1 that are
// not powers of two, in ascending order. parity[PW-2:0] is the XOR of the code
// positions of all set data bits. parity[PW-1] is the overall parity of data
// and Hamming bits.
//
// Optional build macro ECC_ENC_FAULT_INJ_EN adds a fault_inj input. While it is
// high, bit 0 of the copy-1 parity is inverted before the compare. parity_out
// always comes from copy 0, so injection never changes the stored word.

module ecc_175_cal #(
    parameter int DATA_WIDTH   = 175,
    parameter int PARITY_WIDTH = 9
) (
    input  logic                    bypass,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [PARITY_WIDTH-1:0] parity_o
);
    logic [PARITY_WIDTH-2:0] ham;

    // Walk the code positions and fold each set data bit's position into the syndrome.
    always_comb begin
        int d;
        ham = '0;
        d   = 0;
        for (int p = 1; p < (1 << (PARITY_WIDTH-1)); p++) begin
            if (((p & (p - 1)) != 0) && (d < DATA_WIDTH)) begin
                if (data_i[d]) ham = ham ^ p[PARITY_WIDTH-2:0];
                d++;
            end
        end
    end

    // In bypass mode both parity fields are forced to zero.
    always_comb begin
        parity_o = bypass ? '0 : {(^data_i) ^ (^ham), ham};
    end
endmodule

module ecc_175_enc_fault_detc #(
    parameter int DATA_WIDTH   = 175,
    parameter int PARITY_WIDTH = 9,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ecc_fault_detc_en,
    input  logic                 bypass,
    input  logic                 fault_clr,
`ifdef ECC_ENC_FAULT_INJ_EN
    input  logic                 fault_inj,
`endif
    ecc_175_enc_fault_detc_if.slave bus,
    output logic                 ecc_fault,
    output logic                 fault_sticky,
    output logic [CNT_WIDTH-1:0] fault_cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0][PARITY_WIDTH-1:0] par;
    logic [PARITY_WIDTH-1:0]      par1_cmp;
    logic                         accept, mismatch, faulted;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [PARITY_WIDTH-1:0] parity_q;
    logic                    fault_q;
    logic                    sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    // Two identical parity generators that run in lockstep.
    for (genvar g = 0; g < 2; g++) begin : g_cal
        ecc_175_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_cal (
            .bypass   (bypass),
            .data_i   (bus.data_in),
            .parity_o (par[g])
        );
    end

    // Compare copy 0 with copy 1, optionally corrupting copy 1 with the injector.
    always_comb begin
`ifdef ECC_ENC_FAULT_INJ_EN
        par1_cmp = par[1] ^ {{(PARITY_WIDTH-1){1'b0}}, fault_inj};
`else
        par1_cmp = par[1];
`endif
        accept   = bus.in_valid & bus.in_ready;
        mismatch = ecc_fault_detc_en & (par[0] != par1_cmp);
        faulted  = accept & mismatch;
    end

    // Next state of the output stage and the fault bookkeeping.
    always_comb begin
        out_valid_d = out_valid_q;
        if (accept)             out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
        // When faulted and fault_clr arrive together, the fault wins.
        sticky_d = faulted | (sticky_q & ~fault_clr);
        cnt_d    = cnt_q;
        if (faulted)        cnt_d = fault_clr ? CNT_WIDTH'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        else if (fault_clr) cnt_d = '0;
    end

    // Register the output stage and the fault state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            parity_q    <= '0;
            fault_q     <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                data_q   <= bus.data_in;
                parity_q <= par[0];
                fault_q  <= mismatch;
            end
        end
    end

    assign bus.in_ready   = ~out_valid_q | bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.parity_out = parity_q;
    assign ecc_fault      = fault_q & out_valid_q;
    assign fault_sticky   = sticky_q;
    assign fault_cnt      = cnt_q;
endmodule
